fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the CPU front end. Owns the architectural fetch PC and runs a req/ack handshake to instruction memory. Buffers up to two fetched words toward decode with valid/ready flow control. Applies branch redirects from execute; the target is computed there and arrives on redirect_pc. Any redirect squashes all in-flight and buffered fetches.

Parameters:
RESET_PC, 32'h0000_0000, fetch address issued first after reset
PC_INCR, 4, byte increment between sequential fetches

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address; word aligned
imem_ack  in  1  memory accepts the request and returns imem_rdata this cycle
imem_rdata  in  32  fetched instruction, valid only when imem_ack=1
if_valid  out  1  if_inst/if_pc hold a valid instruction for decode
if_inst  out  32  instruction to decode
if_pc  out  32  address of if_inst
id_ready  in  1  decode consumes the entry when if_valid & id_ready
redirect  in  1  taken branch; flush and restart at redirect_pc
redirect_pc  in  32  branch target; bits [1:0] ignored and forced to 0

Behaviour:
- Reset (synchronous, active-high, any state, also mid-transaction): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, skid empty, if_inst=0, if_pc=0.
- Storage: output slot (if_*) plus one skid entry. Order is preserved.
- Handshake rule: once imem_req=1, imem_req and imem_addr stay stable until the cycle imem_ack=1. imem_ack while imem_req=0 is ignored.
- IDLE: imem_req=0. Go to REQ next cycle. A redirect in IDLE updates pc.
- REQ: imem_req=1, imem_addr=pc.
  - On ack without redirect, the word is tagged with imem_addr and pc <= pc+PC_INCR.
  - If the output slot is free or draining this cycle (!if_valid | id_ready), the word loads the slot next cycle and the state stays REQ. Back-to-back acks give one instruction per cycle.
  - Otherwise the word loads skid and the state goes to FULL.
- FULL: imem_req=0. On id_ready, skid moves to the output slot and the state goes to REQ.
- DRAIN: imem_req=1 with the old, stale address held. On ack, rdata is discarded and the state goes to REQ at the current pc.
- Redirect has top priority, applied the same cycle in any non-reset state:
  - pc <= {redirect_pc[31:2],2'b00}.
  - if_valid <= 0 and skid is cleared, even if decode is consuming this cycle; that consume is dropped by decode.
  - REQ without ack -> DRAIN. REQ with coincident ack -> data discarded -> REQ. FULL -> REQ. DRAIN -> stays DRAIN with pc updated.
- Latency: ack in cycle N gives if_valid=1 in N+1. A redirect in cycle N gives the first request to the target in N+1, or after the drain ack.
- if_inst and if_pc are held stable while if_valid & !id_ready.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.

Optional Feature:
FETCH_PERF_EN defined adds two outputs:
- perf_redirects (32): counts cycles with redirect=1.
- perf_stall_cycles (32): counts cycles with if_valid & !id_ready.
Both clear on reset and wrap on overflow. Without the macro these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset released, imem_ack=1 every cycle, id_ready=1 -> imem_addr 0,4,8,C on consecutive cycles; if_pc 0,4,8 one cycle later; no bubbles.
- id_ready=0 with acks at addr 0 and 4 -> slot=0, skid=4, state FULL, imem_req=0. id_ready=1 for two cycles -> if_pc 0 then 4, and a request at 8 resumes.
- REQ at 0x10, imem_ack=0, redirect=1 with redirect_pc=0x103 -> DRAIN holds imem_addr=0x10. Ack with rdata=0xDEAD -> discarded (if_valid stays 0). Next request at 0x100.
- Redirect to 0x200 in the same cycle as ack at 0x20 -> 0x20 data never appears on if_*; next imem_addr=0x200.
- RESET_PC=32'hFFFF_FFFC, acks every cycle -> second request at 0x0000_0000.
- Reset asserted mid-DRAIN -> next cycle imem_req=0, if_valid=0, pc=RESET_PC. With FETCH_PERF_EN, three redirects and five stall cycles -> perf_redirects=3, perf_stall_cycles=5.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer with a req/ack memory handshake, a two-entry
// decode buffer (output slot plus skid) and branch redirect.
// Define FETCH_PERF_EN to add the perf_redirects and perf_stall_cycles counters.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INCR  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_stall_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, FULL, DRAIN} state_t;

    state_t      state, state_n;
    logic [31:0] pc, drain_addr, skid_inst, skid_pc;
    logic        skid_valid;
    logic        ack;
    logic        slot_free;

    assign ack       = imem_req & imem_ack;
    assign slot_free = !if_valid | id_ready;
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next state and request; redirect wins over everything else.
    always_comb begin
        state_n  = state;
        imem_req = 1'b0;
        case (state)
            IDLE: state_n = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (redirect)
                    state_n = ack ? REQ : DRAIN;
                else if (ack && !slot_free)
                    state_n = FULL;
            end
            FULL: state_n = (redirect || id_ready) ? REQ : FULL;
            DRAIN: begin
                imem_req = 1'b1;
                state_n  = ack ? REQ : DRAIN;
            end
            default: state_n = IDLE;
        endcase
    end

    // PC, stale drain address, output slot and skid entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            if_valid   <= 1'b0;
            if_inst    <= 32'h0;
            if_pc      <= 32'h0;
            skid_valid <= 1'b0;
            skid_inst  <= 32'h0;
            skid_pc    <= 32'h0;
        end else begin
            if (state == REQ)
                drain_addr <= pc;
            if (redirect) begin
                pc         <= {redirect_pc[31:2], 2'b00};
                if_valid   <= 1'b0;
                skid_valid <= 1'b0;
            end else if (state == REQ && ack) begin
                pc <= pc + PC_INCR;
                if (slot_free) begin
                    if_valid <= 1'b1;
                    if_inst  <= imem_rdata;
                    if_pc    <= pc;
                end else begin
                    skid_valid <= 1'b1;
                    skid_inst  <= imem_rdata;
                    skid_pc    <= pc;
                end
            end else if (state == FULL && id_ready) begin
                if_valid   <= skid_valid;
                if_inst    <= skid_inst;
                if_pc      <= skid_pc;
                skid_valid <= 1'b0;
            end else if (if_valid && id_ready) begin
                if_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Free-running wrap-around event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_redirects    <= 32'h0;
            perf_stall_cycles <= 32'h0;
        end else begin
            perf_redirects    <= perf_redirects + {31'h0, redirect};
            perf_stall_cycles <= perf_stall_cycles + {31'h0, if_valid & !id_ready};
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of fetch_ctrl; a second instance covers PC wrap.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack, if_valid, id_ready, redirect;
    logic [31:0] imem_addr, imem_rdata, if_inst, if_pc, redirect_pc;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_inst, w_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_redirects, perf_stall_cycles, w_perf_r, w_perf_s;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_inst(if_inst), .if_pc(if_pc), .id_ready(id_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
        , .perf_redirects(perf_redirects), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(1'b1), .imem_rdata(32'h0), .if_valid(w_valid),
        .if_inst(w_inst), .if_pc(w_pc), .id_ready(1'b1),
        .redirect(1'b0), .redirect_pc(32'h0)
`ifdef FETCH_PERF_EN
        , .perf_redirects(w_perf_r), .perf_stall_cycles(w_perf_s)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; id_ready = 1'b1;
        redirect = 1'b0; redirect_pc = 32'h0;
        tick(); tick();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("w_rst_addr", w_addr, 32'hFFFF_FFFC);

        // streaming: ack every cycle, decode always ready
        reset = 1'b0; imem_ack = 1'b1;
        tick();
        chk("s0_req", {31'h0, imem_req}, 32'h1);
        chk("s0_addr", imem_addr, 32'h0);
        chk("s0_valid", {31'h0, if_valid}, 32'h0);
        chk("w_first_addr", w_addr, 32'hFFFF_FFFC);
        imem_rdata = 32'h1000;
        tick();
        chk("s1_addr", imem_addr, 32'h4);
        chk("s1_valid", {31'h0, if_valid}, 32'h1);
        chk("s1_pc", if_pc, 32'h0);
        chk("s1_inst", if_inst, 32'h1000);
        chk("w_wrap_addr", w_addr, 32'h0);
        chk("w_wrap_pc", w_pc, 32'hFFFF_FFFC);
        imem_rdata = 32'h1004;
        tick();
        chk("s2_addr", imem_addr, 32'h8);
        chk("s2_pc", if_pc, 32'h4);
        imem_rdata = 32'h1008;
        tick();
        chk("s3_addr", imem_addr, 32'hC);
        chk("s3_pc", if_pc, 32'h8);
        chk("s3_inst", if_inst, 32'h1008);
        chk("s3_valid", {31'h0, if_valid}, 32'h1);

        // backpressure fills slot and skid
        reset = 1'b1; imem_ack = 1'b0; id_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h2000;
        tick();
        chk("bp0_valid", {31'h0, if_valid}, 32'h1);
        chk("bp0_pc", if_pc, 32'h0);
        chk("bp0_addr", imem_addr, 32'h4);
        imem_rdata = 32'h2004;
        tick();
        chk("full_req", {31'h0, imem_req}, 32'h0);
        chk("full_pc", if_pc, 32'h0);
        chk("full_inst", if_inst, 32'h2000);
        imem_rdata = 32'hBAD0;
        tick();
        chk("full_hold_req", {31'h0, imem_req}, 32'h0);
        chk("full_hold_pc", if_pc, 32'h0);
        imem_ack = 1'b0; id_ready = 1'b1;
        tick();
        chk("skid_pc", if_pc, 32'h4);
        chk("skid_inst", if_inst, 32'h2004);
        chk("resume_req", {31'h0, imem_req}, 32'h1);
        chk("resume_addr", imem_addr, 32'h8);
        tick();
        chk("drained_valid", {31'h0, if_valid}, 32'h0);
        chk("drained_addr", imem_addr, 32'h8);

        // redirect with coincident ack to get REQ at 0x10 (target bits [1:0] dropped)
        redirect = 1'b1; redirect_pc = 32'h12; imem_ack = 1'b1; imem_rdata = 32'hBAD1;
        tick();
        chk("r10_addr", imem_addr, 32'h10);
        chk("r10_valid", {31'h0, if_valid}, 32'h0);
        // redirect without ack -> DRAIN holds stale address
        redirect_pc = 32'h103; imem_ack = 1'b0;
        tick();
        chk("drain_req", {31'h0, imem_req}, 32'h1);
        chk("drain_addr", imem_addr, 32'h10);
        redirect = 1'b0;
        tick();
        chk("drain_hold", imem_addr, 32'h10);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD;
        tick();
        chk("drain_disc_valid", {31'h0, if_valid}, 32'h0);
        chk("after_drain_addr", imem_addr, 32'h100);
        chk("after_drain_req", {31'h0, imem_req}, 32'h1);

        // REQ at 0x20, then redirect to 0x200 coincident with its ack
        redirect = 1'b1; redirect_pc = 32'h20; imem_rdata = 32'hBAD2;
        tick();
        chk("r20_addr", imem_addr, 32'h20);
        redirect_pc = 32'h200; imem_rdata = 32'h2020;
        tick();
        chk("coinc_valid", {31'h0, if_valid}, 32'h0);
        chk("coinc_addr", imem_addr, 32'h200);
        redirect = 1'b0; imem_rdata = 32'h3000;
        tick();
        chk("tgt_valid", {31'h0, if_valid}, 32'h1);
        chk("tgt_pc", if_pc, 32'h200);
        chk("tgt_inst", if_inst, 32'h3000);
        chk("tgt_next_addr", imem_addr, 32'h204);

        // reset in the middle of a drain
        imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        chk("md_addr", imem_addr, 32'h204);
        reset = 1'b1; redirect = 1'b0;
        tick();
        chk("md_rst_req", {31'h0, imem_req}, 32'h0);
        chk("md_rst_valid", {31'h0, if_valid}, 32'h0);
        chk("md_rst_addr", imem_addr, 32'h0);

`ifdef FETCH_PERF_EN
        chk("perf_r_rst", perf_redirects, 32'h0);
        chk("perf_s_rst", perf_stall_cycles, 32'h0);
        reset = 1'b0; id_ready = 1'b0;
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h4000;
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h400;
        for (int i = 0; i < 3; i++) tick();
        redirect = 1'b0;
        tick();
        chk("perf_redirects", perf_redirects, 32'h3);
        chk("perf_stalls", perf_stall_cycles, 32'h5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
